// File: rtl/mem_fifo_pkg.sv
// Shared constants, grant/priority encodings and pointer helper for the Memory FIFO controller.
// Optional feature macro used by mem_fifo_ctrl: FIFO_ERR_STICKY_EN.
package mem_fifo_pkg;

  localparam int unsigned DEPTH = 101;
  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 11;
  localparam int unsigned CW    = 7;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_PUSH = 2'b01,
    GNT_POP  = 2'b10
  } gnt_e;

  typedef enum logic {
    PRIO_PUSH = 1'b0,
    PRIO_POP  = 1'b1
  } prio_e;

  // DEPTH is not a power of two, so the wrap is explicit.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

endpackage

// File: rtl/mem_fifo_arb.sv
// Push/pop round-robin arbiter: a single eligible side always wins; contested
// cycles are settled by prio, which flips only after a contested cycle.
module mem_fifo_arb
  import mem_fifo_pkg::*;
(
  input  logic  push_ok,
  input  logic  pop_ok,
  input  prio_e prio,
  output gnt_e  grant,
  output prio_e prio_nxt
);

  always_comb begin
    grant    = GNT_NONE;
    prio_nxt = prio;
    if (push_ok && pop_ok) begin
      grant    = (prio == PRIO_PUSH) ? GNT_PUSH : GNT_POP;
      prio_nxt = (prio == PRIO_PUSH) ? PRIO_POP : PRIO_PUSH;
    end else if (push_ok) begin
      grant = GNT_PUSH;
    end else if (pop_ok) begin
      grant = GNT_POP;
    end
  end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller in front of the 101-entry Memory: arbitrates push/pop, never drives
// WriteEn and ReadEn together. `define FIFO_ERR_STICKY_EN adds sticky OvfErr/UdfErr.
module mem_fifo_ctrl
  import mem_fifo_pkg::*;
(
  input  logic          MCLK,
  input  logic          MRST,
  input  logic          PushReq,
  input  logic [DW-1:0] PushData,
  output logic          PushAck,
  input  logic          PopReq,
  output logic          PopAck,
  output logic          Full,
  output logic          Empty,
  output logic [CW-1:0] Count,
  output logic          WriteEn,
  output logic          ReadEn,
  output logic [AW-1:0] WAddress,
  output logic [AW-1:0] RAddress,
  output logic [DW-1:0] InData,
  output logic          RdValid
`ifdef FIFO_ERR_STICKY_EN
  ,
  output logic          OvfErr,
  output logic          UdfErr
`endif
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          push_ok;
  logic          pop_ok;
  logic          do_push;
  logic          do_pop;
  prio_e         prio;
  prio_e         prio_nxt;
  gnt_e          grant;

  assign push_ok = PushReq && !Full;
  assign pop_ok  = PopReq && !Empty;

  mem_fifo_arb u_arb (
    .push_ok  (push_ok),
    .pop_ok   (pop_ok),
    .prio     (prio),
    .grant    (grant),
    .prio_nxt (prio_nxt)
  );

  assign do_push = (grant == GNT_PUSH);
  assign do_pop  = (grant == GNT_POP);
  assign PushAck = do_push;
  assign PopAck  = do_pop;

  always_comb begin
    count_nxt = Count;
    if (do_push) begin
      count_nxt = Count + CW'(1);
    end else if (do_pop) begin
      count_nxt = Count - CW'(1);
    end
  end

  // Memory-side strobes are registered one cycle behind the ack; the read result
  // appears the cycle after ReadEn, hence RdValid follows ReadEn.
  always_ff @(posedge MCLK) begin
    if (MRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Full     <= 1'b0;
      Empty    <= 1'b1;
      prio     <= PRIO_PUSH;
      WriteEn  <= 1'b0;
      ReadEn   <= 1'b0;
      RdValid  <= 1'b0;
      WAddress <= '0;
      RAddress <= '0;
      InData   <= '0;
    end else begin
      Count   <= count_nxt;
      Full    <= (count_nxt == CW'(DEPTH));
      Empty   <= (count_nxt == '0);
      prio    <= prio_nxt;
      WriteEn <= do_push;
      ReadEn  <= do_pop;
      RdValid <= ReadEn;
      if (do_push) begin
        WAddress <= wr_ptr;
        InData   <= PushData;
        wr_ptr   <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        RAddress <= rd_ptr;
        rd_ptr   <= ptr_inc(rd_ptr);
      end
    end
  end

`ifdef FIFO_ERR_STICKY_EN
  always_ff @(posedge MCLK) begin
    if (MRST) begin
      OvfErr <= 1'b0;
      UdfErr <= 1'b0;
    end else begin
      if (PushReq && Full) begin
        OvfErr <= 1'b1;
      end
      if (PopReq && Empty) begin
        UdfErr <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Self-checking bench for mem_fifo_ctrl with a behavioural Memory model and a
// scoreboard of expected read data. Honours FIFO_ERR_STICKY_EN when defined.
module tb_mem_fifo_ctrl;
  import mem_fifo_pkg::*;

  logic          MCLK;
  logic          MRST;
  logic          PushReq;
  logic [DW-1:0] PushData;
  logic          PushAck;
  logic          PopReq;
  logic          PopAck;
  logic          Full;
  logic          Empty;
  logic [CW-1:0] Count;
  logic          WriteEn;
  logic          ReadEn;
  logic [AW-1:0] WAddress;
  logic [AW-1:0] RAddress;
  logic [DW-1:0] InData;
  logic          RdValid;
`ifdef FIFO_ERR_STICKY_EN
  logic          OvfErr;
  logic          UdfErr;
`endif

  mem_fifo_ctrl dut (
    .MCLK     (MCLK),
    .MRST     (MRST),
    .PushReq  (PushReq),
    .PushData (PushData),
    .PushAck  (PushAck),
    .PopReq   (PopReq),
    .PopAck   (PopAck),
    .Full     (Full),
    .Empty    (Empty),
    .Count    (Count),
    .WriteEn  (WriteEn),
    .ReadEn   (ReadEn),
    .WAddress (WAddress),
    .RAddress (RAddress),
    .InData   (InData),
    .RdValid  (RdValid)
`ifdef FIFO_ERR_STICKY_EN
    ,
    .OvfErr   (OvfErr),
    .UdfErr   (UdfErr)
`endif
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // Memory: ignores cycles with both enables, registered read.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] OutData;
  always @(posedge MCLK) begin
    if (WriteEn && !ReadEn && (int'(WAddress) < DEPTH)) mem[int'(WAddress)] <= InData;
    else if (ReadEn && !WriteEn && (int'(RAddress) < DEPTH)) OutData <= mem[int'(RAddress)];
  end

  int checks;
  int errors;

  logic [DW-1:0] q[$];
  logic [DW-1:0] rdp[$];
  int unsigned   m_wptr, m_rptr;
  logic          m_prio;
  logic          e_wen, e_ren, e_rdv;
  logic [AW-1:0] e_waddr, e_raddr;
  logic [DW-1:0] e_indata;
  logic          m_ovf, m_udf;

  logic          s_pa, s_po, s_wen, s_ren, s_rdv, s_full, s_empty;
  logic [CW-1:0] s_cnt;
  logic [AW-1:0] s_waddr;

  typedef struct {
    logic          push;
    logic [DW-1:0] d;
    logic          pop;
    logic          pa;
    logic          po;
    int unsigned   cnt;
    logic          wen;
    logic          ren;
    logic          rdv;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rdp.delete();
    m_wptr = 0; m_rptr = 0; m_prio = 1'b0;
    e_wen = 1'b0; e_ren = 1'b0; e_rdv = 1'b0;
    e_waddr = '0; e_raddr = '0; e_indata = '0;
    m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  // One clock cycle: drive at posedge+1, check and sample at negedge, update model.
  task automatic tick(input logic pr, input logic [DW-1:0] pd, input logic po, input logic rst);
    logic full, empty, pok, ook, gp, go, nrdv;
    PushReq = pr; PushData = pd; PopReq = po; MRST = rst;
    @(negedge MCLK);
    s_pa = PushAck; s_po = PopAck; s_wen = WriteEn; s_ren = ReadEn; s_rdv = RdValid;
    s_full = Full; s_empty = Empty; s_cnt = Count; s_waddr = WAddress;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    check("Count", 32'(Count), 32'(q.size()));
    check("Full", 32'(Full), 32'(full));
    check("Empty", 32'(Empty), 32'(empty));
    check("WriteEn", 32'(WriteEn), 32'(e_wen));
    check("ReadEn", 32'(ReadEn), 32'(e_ren));
    check("RdValid", 32'(RdValid), 32'(e_rdv));
    check("WAddress", 32'(WAddress), 32'(e_waddr));
    check("RAddress", 32'(RAddress), 32'(e_raddr));
    check("InData", 32'(InData), 32'(e_indata));
    check("EnExcl", 32'(WriteEn && ReadEn), 32'(0));
`ifdef FIFO_ERR_STICKY_EN
    check("OvfErr", 32'(OvfErr), 32'(m_ovf));
    check("UdfErr", 32'(UdfErr), 32'(m_udf));
`endif
    if (RdValid) begin
      if (rdp.size() == 0) begin
        checks++; errors++;
        $display("FAIL OutData: RdValid with no read pending at %0t", $time);
      end else begin
        check("OutData", 32'(OutData), 32'(rdp.pop_front()));
      end
    end
    if (rst) begin
      model_reset();
    end else begin
      pok = pr && !full;
      ook = po && !empty;
      gp  = pok && (!ook || (m_prio == 1'b0));
      go  = ook && !gp;
      if (pok && ook) m_prio = ~m_prio;
      check("PushAck", 32'(PushAck), 32'(gp));
      check("PopAck", 32'(PopAck), 32'(go));
      if (pr && full) m_ovf = 1'b1;
      if (po && empty) m_udf = 1'b1;
      nrdv  = e_ren;
      e_wen = gp;
      e_ren = go;
      e_rdv = nrdv;
      if (gp) begin
        e_waddr  = AW'(m_wptr);
        e_indata = pd;
        q.push_back(pd);
        m_wptr = (m_wptr == DEPTH - 1) ? 0 : m_wptr + 1;
      end
      if (go) begin
        e_raddr = AW'(m_rptr);
        rdp.push_back(q.pop_front());
        m_rptr = (m_rptr == DEPTH - 1) ? 0 : m_rptr + 1;
      end
    end
    @(posedge MCLK);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    MRST = 1'b1; PushReq = 1'b0; PopReq = 1'b0; PushData = '0;
    repeat (2) @(posedge MCLK);
    #1;
    model_reset();

    // Reset state
    check("rst_Count", 32'(Count), 32'(0));
    check("rst_Empty", 32'(Empty), 32'(1));
    check("rst_Full", 32'(Full), 32'(0));
    check("rst_WriteEn", 32'(WriteEn), 32'(0));
    check("rst_ReadEn", 32'(ReadEn), 32'(0));
    check("rst_RdValid", 32'(RdValid), 32'(0));
    check("rst_WAddress", 32'(WAddress), 32'(0));
    check("rst_InData", 32'(InData), 32'(0));

    // push 0x123 then pop; then fill to 5 and contend for 4 cycles
    //                push  data    pop  pa  po cnt wen ren rdv
    tbl.push_back('{1'b1, 11'h123, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 11'h010, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 11'h011, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 11'h012, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 11'h013, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 11'h014, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 11'h020, 1'b1, 1'b1, 1'b0, 5, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 11'h021, 1'b1, 1'b0, 1'b1, 6, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 11'h022, 1'b1, 1'b1, 1'b0, 5, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 11'h023, 1'b1, 1'b0, 1'b1, 6, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b1});

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].push, tbl[i].d, tbl[i].pop, 1'b0);
      check($sformatf("tbl%0d_PushAck", i), 32'(s_pa), 32'(tbl[i].pa));
      check($sformatf("tbl%0d_PopAck", i), 32'(s_po), 32'(tbl[i].po));
      check($sformatf("tbl%0d_Count", i), 32'(s_cnt), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_WriteEn", i), 32'(s_wen), 32'(tbl[i].wen));
      check($sformatf("tbl%0d_ReadEn", i), 32'(s_ren), 32'(tbl[i].ren));
      check($sformatf("tbl%0d_RdValid", i), 32'(s_rdv), 32'(tbl[i].rdv));
    end
    repeat (5) tick(1'b0, '0, 1'b1, 1'b0);
    repeat (2) tick(1'b0, '0, 1'b0, 1'b0);
    check("t3_drained", 32'(s_cnt), 32'(0));

    // Fill 0..100 from reset, overflow attempt, full with push+pop, wrap
    tick(1'b0, '0, 1'b0, 1'b1);
    for (int v = 0; v < DEPTH; v++) tick(1'b1, DW'(v), 1'b0, 1'b0);
    tick(1'b1, 11'h7FF, 1'b0, 1'b0);
    check("t2_full_flag", 32'(s_full), 32'(1));
    check("t2_full_cnt", 32'(s_cnt), 32'(DEPTH));
    check("t2_push_at_full", 32'(s_pa), 32'(0));
    tick(1'b1, 11'h400, 1'b1, 1'b0);
    check("t4_pop_wins", 32'(s_po), 32'(1));
    check("t4_push_held", 32'(s_pa), 32'(0));
    tick(1'b1, 11'h401, 1'b0, 1'b0);
    check("t4_push_next", 32'(s_pa), 32'(1));
    tick(1'b0, '0, 1'b0, 1'b0);
    check("t2_wrap_wen", 32'(s_wen), 32'(1));
    check("t2_wrap_addr", 32'(s_waddr), 32'(0));
    for (int v = 0; v < DEPTH; v++) tick(1'b0, '0, 1'b1, 1'b0);
    repeat (2) tick(1'b0, '0, 1'b0, 1'b0);
    check("t2_empty", 32'(s_empty), 32'(1));

    // Reset with a read in flight
    tick(1'b1, 11'h055, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    check("t5_popack", 32'(s_po), 32'(1));
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b0);
    check("t5_rdvalid", 32'(s_rdv), 32'(0));
    check("t5_count", 32'(s_cnt), 32'(0));
    check("t5_empty", 32'(s_empty), 32'(1));
    check("t5_readen", 32'(s_ren), 32'(0));
    tick(1'b0, '0, 1'b0, 1'b0);
    check("t5_rdvalid2", 32'(s_rdv), 32'(0));

    // Illegal requests: pop on empty, push at full
    tick(1'b0, '0, 1'b1, 1'b0);
    check("t6_pop_empty", 32'(s_po), 32'(0));
    tick(1'b0, '0, 1'b0, 1'b0);
    check("t6_cnt_empty", 32'(s_cnt), 32'(0));
    check("t6_still_empty", 32'(s_empty), 32'(1));
`ifdef FIFO_ERR_STICKY_EN
    check("t6_udf_set", 32'(UdfErr), 32'(1));
    check("t6_ovf_clear", 32'(OvfErr), 32'(0));
`endif
    for (int v = 0; v < DEPTH; v++) tick(1'b1, DW'(v + 200), 1'b0, 1'b0);
    tick(1'b1, 11'h3FF, 1'b0, 1'b0);
    check("t6_push_full", 32'(s_pa), 32'(0));
    tick(1'b0, '0, 1'b0, 1'b0);
    check("t6_cnt_full", 32'(s_cnt), 32'(DEPTH));
`ifdef FIFO_ERR_STICKY_EN
    check("t6_ovf_set", 32'(OvfErr), 32'(1));
    check("t6_udf_sticky", 32'(UdfErr), 32'(1));
`endif
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b0);
`ifdef FIFO_ERR_STICKY_EN
    check("t6_ovf_rst", 32'(OvfErr), 32'(0));
    check("t6_udf_rst", 32'(UdfErr), 32'(0));
`endif
    check("t6_cnt_rst", 32'(s_cnt), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
